btn_conditioner: RTL and testbench

//   Multi-channel push-button front end for the Basys3 sorting-visualiser UI.
//   Per button: 2-flop synchroniser, stable-count debounce, one-cycle press/release

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_conditioner_if.sv | 21 ++
 rtl/btn_channel.sv | 111 +++++++++++
 rtl/btn_conditioner.sv | 52 +++++
 tb/tb_btn_conditioner.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button front end.
package btn_pkg;

    // Default timing at a 100 MHz system clock.
    localparam int DEBOUNCE_20MS = 2_000_000;
    localparam int HOLD_500MS    = 50_000_000;
    localparam int REPEAT_100MS  = 10_000_000;

    typedef enum logic {
        PH_HOLD   = 1'b0,
        PH_REPEAT = 1'b1
    } rep_phase_e;

    // Width of a counter that must hold values 0..max_val.
    function automatic int clog2_cnt(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between board pins and the UI control logic.
interface btn_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;
    logic             any_press;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_repeat, any_press
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_repeat, any_press
    );
endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, stable-count debounce,
// press/release pulses and optional hold-to-auto-repeat.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int REPEAT_EN       = 1,
    parameter int HOLD_CYCLES     = HOLD_500MS,
    parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o,
    output logic press_d_o
);
    localparam int               CNT_W    = clog2_cnt(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             accept;

    assign accept = (s2_q != level_q) && (cnt_q == CNT_LAST);

    // Any sample matching the current level restarts the stability count.
    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q != level_q) begin
            if (accept) begin
                level_d   = s2_q;
                press_d   = s2_q;
                release_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= btn_raw_i;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign press_d_o = press_d;

    if (REPEAT_EN != 0) begin : g_rep
        localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
        localparam int HOLD_W   = clog2_cnt(HOLD_MAX);

        rep_phase_e        phase_q;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] target;
        logic              repeat_q;

        assign target = (phase_q == PH_REPEAT) ? HOLD_W'(REPEAT_CYCLES - 1)
                                               : HOLD_W'(HOLD_CYCLES - 1);

        // Counter never passes target, so it cannot wrap into a stray pulse;
        // the release edge itself (accept while level=1) clears it.
        always_ff @(posedge clk) begin
            if (rst) begin
                phase_q  <= PH_HOLD;
                hold_q   <= '0;
                repeat_q <= 1'b0;
            end else begin
                repeat_q <= 1'b0;
                if (!level_q || accept) begin
                    phase_q <= PH_HOLD;
                    hold_q  <= '0;
                end else if (hold_q == target) begin
                    phase_q  <= PH_REPEAT;
                    hold_q   <= '0;
                    repeat_q <= 1'b1;
                end else begin
                    hold_q <= hold_q + HOLD_W'(1);
                end
            end
        end

        assign repeat_o = repeat_q;
    end else begin : g_norep
        assign repeat_o = 1'b0;
    end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: N_BTN independent conditioned
// channels plus a registered any_press summary.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int REPEAT_EN       = 1,
    parameter int HOLD_CYCLES     = HOLD_500MS,
    parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
    input  logic               clk,
    input  logic               rst,
    btn_conditioner_if.slave   bus
);
    if (N_BTN < 1 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("btn_conditioner: N_BTN and all *_CYCLES parameters must be >= 1");
    end

    logic [N_BTN-1:0] press_d;
    logic             any_press_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_raw_i (bus.btn_raw[i]),
            .level_o   (bus.btn_level[i]),
            .press_o   (bus.btn_press[i]),
            .release_o (bus.btn_release[i]),
            .repeat_o  (bus.btn_repeat[i]),
            .press_d_o (press_d[i])
        );
    end

    // Registered from the channels' next-state so it lines up with btn_press.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_d;
        end
    end

    assign bus.any_press = any_press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: vector table, directed corner
// sequences and randomized bouncing inputs against a window-based model.
module tb_btn_conditioner;
    localparam int N = 2;
    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] raw = '0;
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    btn_conditioner_if #(.N_BTN(N)) ifa ();
    btn_conditioner_if #(.N_BTN(N)) ifb ();
    assign ifa.btn_raw = raw;
    assign ifb.btn_raw = raw;

    btn_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );

    btn_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
    ) dut_nr (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    // Reference model: level flips when the last D synchronised samples all
    // disagree with it; repeats are derived from elapsed time since the press.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_prs = '0, m_rel = '0, m_rep = '0;
    logic         m_any = 1'b0;
    logic [N-1:0] m_win [D] = '{default: '0};
    int           m_pt  [N] = '{default: 0};
    int           m_cyc = 0;

    always @(posedge clk) begin : ref_model
        logic [N-1:0] win_n [D];
        int           pt_n  [N];
        logic [N-1:0] lvl, prs, rel, rep;
        bit           all_diff;
        int           el;
        win_n[0] = m_s2;
        for (int k = 1; k < D; k++) win_n[k] = m_win[k-1];
        pt_n = m_pt;
        lvl = m_lvl; prs = '0; rel = '0; rep = '0;
        for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) if (win_n[k][i] == m_lvl[i]) all_diff = 1'b0;
            if (all_diff) begin
                lvl[i] = ~m_lvl[i];
                if (lvl[i]) begin
                    prs[i]  = 1'b1;
                    pt_n[i] = m_cyc;
                end else begin
                    rel[i] = 1'b1;
                end
            end else if (m_lvl[i]) begin
                el = m_cyc - m_pt[i];
                if (el == H || (el > H && ((el - H) % R) == 0)) rep[i] = 1'b1;
            end
        end
        if (rst) begin
            for (int k = 0; k < D; k++) win_n[k] = '0;
            m_win <= win_n;
            m_s1 <= '0; m_s2 <= '0; m_lvl <= '0;
            m_prs <= '0; m_rel <= '0; m_rep <= '0; m_any <= 1'b0;
        end else begin
            m_win <= win_n;
            m_pt  <= pt_n;
            m_s2  <= m_s1;
            m_s1  <= raw;
            m_lvl <= lvl; m_prs <= prs; m_rel <= rel; m_rep <= rep; m_any <= |prs;
        end
        m_cyc <= m_cyc + 1;
    end

    function automatic logic [4*N:0] outs_a();
        return {ifa.btn_level, ifa.btn_press, ifa.btn_release, ifa.btn_repeat, ifa.any_press};
    endfunction

    function automatic logic [4*N:0] outs_b();
        return {ifb.btn_level, ifb.btn_press, ifb.btn_release, ifb.btn_repeat, ifb.any_press};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         r;
        logic [N-1:0] raw;
        logic [4*N:0] exp;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic r, input logic [N-1:0] rw, input logic [N-1:0] lv,
                       input logic [N-1:0] pr, input logic [N-1:0] rl,
                       input logic [N-1:0] rp, input int cnt);
        vec_t v;
        v.r   = r;
        v.raw = rw;
        v.exp = {lv, pr, rl, rp, |pr};
        for (int j = 0; j < cnt; j++) vt.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        raw = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [40:0]  rep_m, rel_m, exp_rep;
        logic [4*N:0] model_a, model_b;
        int           found, lat, rep_a, rep_b;
        int           len [N];

        // Table: reset, clean press, glitch, repeats, release, bounce.
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5);   // edges k..k+4
        add(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);   // k+5 = P
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1);   // P+1
        add(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1);   // P+2 one-cycle glitch
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 7);   // P+3..P+9
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1);   // P+10 first repeat
        add(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2);   // P+11..P+12
        add(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1);   // P+13 repeat
        add(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2);   // P+14..P+15
        add(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);   // P+16 release, repeat suppressed
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4);
        add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1);   // bounce 1,0,1,1,0
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5);   // steady 1 from b+5
        add(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);   // b+10 single press
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2);

        @(negedge clk);
        foreach (vt[idx]) begin
            rst = vt[idx].r;
            raw = vt[idx].raw;
            @(negedge clk);
            chk($sformatf("table%0d", idx), outs_a(), vt[idx].exp);
        end

        // Hold for repeats, then release.
        do_reset();
        raw = 2'b01;
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            @(negedge clk);
            if (ifa.btn_press[0]) found = 1;
        end
        chk("t3_press_seen", found, 1);
        rep_m = '0;
        rel_m = '0;
        for (int off = 1; off <= 40; off++) begin
            @(negedge clk);
            rep_m[off] = ifa.btn_repeat[0];
            rel_m[off] = ifa.btn_release[0];
            if (off == 24) raw = 2'b00;
        end
        exp_rep = '0;
        for (int off = H; off <= 28; off += R) exp_rep[off] = 1'b1;
        chk("t3_repeat_offsets", rep_m, exp_rep);
        chk("t3_release_offsets", rel_m, 41'd1 << 30);

        // Simultaneous press on both channels; repeat-disabled instance.
        do_reset();
        raw = 2'b11;
        lat = 0;
        for (int t = 1; t <= 20 && lat == 0; t++) begin
            @(negedge clk);
            if (ifa.btn_press != '0) lat = t;
        end
        chk("t4_latency", lat, D + 2);
        chk("t4_press_both", ifa.btn_press, 2'b11);
        chk("t4_any_press", ifa.any_press, 1'b1);
        chk("t4_nr_press_both", ifb.btn_press, 2'b11);
        rep_a = 0;
        rep_b = 0;
        for (int off = 1; off <= 15; off++) begin
            @(negedge clk);
            if (ifa.btn_repeat == 2'b11) rep_a++;
            if (ifb.btn_repeat != '0) rep_b++;
        end
        chk("t4_repeat_en1", rep_a, 2);
        chk("t4_repeat_en0", rep_b, 0);

        // Reset mid-debounce and mid-repeat with the button still held.
        do_reset();
        raw = 2'b01;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_debounce", outs_a(), '0);
        rst = 1'b0;
        lat = 0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (ifa.btn_press[0] && lat == 0) lat = t;
        end
        chk("t5_press_after_rst", lat, D + 2);
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            @(negedge clk);
            if (ifa.btn_repeat[0]) found = 1;
        end
        chk("t5_repeat_seen", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_repeat", outs_a(), '0);
        chk("t5_rst_repeat_nr", outs_b(), '0);
        rst = 1'b0;
        lat = 0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (ifa.btn_press[0] && lat == 0) lat = t;
        end
        chk("t5_press_after_rst2", lat, D + 2);

        // Randomized bouncing/holding against the reference model.
        for (int i = 0; i < N; i++) len[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (len[i] == 0) begin
                    raw[i] = 1'($urandom_range(0, 1));
                    len[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 40))
                                                         : int'($urandom_range(1, 6));
                end
                len[i]--;
            end
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            model_a = {m_lvl, m_prs, m_rel, m_rep, m_any};
            model_b = {m_lvl, m_prs, m_rel, {N{1'b0}}, m_any};
            chk("rand_repeat_en1", outs_a(), model_a);
            chk("rand_repeat_en0", outs_b(), model_b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
